// File: rtl/stream_scoreboard_pkg.sv
// Shared types and helpers for the stream scoreboard.
package stream_scoreboard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    // Widest values the helpers accept; callers zero-extend into them and
    // cast the result back to their own width.
    localparam int MAX_W        = 64;
    localparam int MAX_D        = 2048;
    localparam int MAX_LANES    = 64;
    localparam int MAX_D_AW     = $clog2(MAX_D);
    localparam int MAX_LANES_AW = $clog2(MAX_LANES);

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] lim;
        if (w >= MAX_W) lim = '1;
        else            lim = (MAX_W'(1) << w) - MAX_W'(1);
        return (v >= lim) ? lim : v + MAX_W'(1);
    endfunction

    // One bit per lane: set when the lane is enabled in mask and any bit
    // of that lane differs between a and b.
    function automatic logic [MAX_LANES-1:0] masked_lane_cmp(
        input logic [MAX_D-1:0]     a,
        input logic [MAX_D-1:0]     b,
        input logic [MAX_LANES-1:0] mask,
        input int                   lane_w,
        input int                   lanes
    );
        logic [MAX_LANES-1:0] hit;
        hit = '0;
        for (int k = 0; k < MAX_D; k++) begin
            if (k < lane_w * lanes && a[MAX_D_AW'(k)] != b[MAX_D_AW'(k)])
                hit[MAX_LANES_AW'(k / lane_w)] = 1'b1;
        end
        return hit & mask;
    endfunction

endpackage

// File: rtl/stream_scoreboard_if.sv
// Bundle of the expected-data port, the passive monitor tap, control and
// result signals of the stream scoreboard.
//
// Handshake: a transfer happens on a rising clk edge where vld and rdy are
// both high. A source holds vld and data stable until that edge; rdy may
// change freely. On the expected port the scoreboard owns exp_rdy_o; on the
// monitor tap both mon_vld_i and mon_rdy_i belong to the observed stream.
interface stream_scoreboard_if #(
    parameter int LANE_W    = 16,
    parameter int NUM_LANES = 8,
    parameter int CNT_W     = 16
) ();
    localparam int D = LANE_W * NUM_LANES;

    logic                 clear_i;
    logic                 exp_vld_i;
    logic [D-1:0]         exp_data_i;
    logic                 exp_rdy_o;
    logic                 mon_vld_i;
    logic                 mon_rdy_i;
    logic [D-1:0]         mon_data_i;
    logic [NUM_LANES-1:0] lane_mask_i;
    logic [CNT_W-1:0]     total_i;
    logic [CNT_W-1:0]     beat_cnt_o;
    logic [CNT_W-1:0]     err_cnt_o;
    logic                 err_o;
    logic [CNT_W-1:0]     first_err_beat_o;
    logic [NUM_LANES-1:0] first_err_lanes_o;
    logic                 underflow_o;
    logic                 overrun_o;
    logic                 done_o;

    // Scoreboard side.
    modport slave (
        input  clear_i, exp_vld_i, exp_data_i, mon_vld_i, mon_rdy_i, mon_data_i,
               lane_mask_i, total_i,
        output exp_rdy_o, beat_cnt_o, err_cnt_o, err_o, first_err_beat_o,
               first_err_lanes_o, underflow_o, overrun_o, done_o
    );

    // Bench / self-test controller side.
    modport master (
        output clear_i, exp_vld_i, exp_data_i, mon_vld_i, mon_rdy_i, mon_data_i,
               lane_mask_i, total_i,
        input  exp_rdy_o, beat_cnt_o, err_cnt_o, err_o, first_err_beat_o,
               first_err_lanes_o, underflow_o, overrun_o, done_o
    );
endinterface

// File: rtl/stream_scoreboard_fifo.sv
// Synchronous expected-data FIFO. Pointers carry one extra MSB so full and
// empty come straight from registered pointers; head data is read
// combinationally from the entry at the read pointer.
module stream_scoreboard_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_ok, pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign cnt_o   = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Advance pointers on accepted push / pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/stream_scoreboard.sv
// Passive vld/rdy stream scoreboard: pops one queued expectation per
// observed beat, compares lane-by-lane under a mask, and keeps counts,
// first-error capture, sticky flags and a RUN/DONE state.
module stream_scoreboard
    import stream_scoreboard_pkg::*;
#(
    parameter int LANE_W    = 16,
    parameter int NUM_LANES = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_scoreboard_if.slave     sb,
    output state_e                 dbg_state_o,
    output logic [$clog2(DEPTH):0] dbg_fifo_cnt_o
);
    localparam int D = LANE_W * NUM_LANES;

    logic                 fifo_rst, push, pop, beat, full, empty, beat_err;
    logic [D-1:0]         head;
    logic [NUM_LANES-1:0] mis_lanes, err_lanes;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]     fbeat_q, fbeat_d;
    logic [NUM_LANES-1:0] flanes_q, flanes_d;
    logic                 err_q, err_d;
    logic                 under_q, under_d;
    logic                 over_q, over_d;

    // clear_i behaves as reset; the FIFO reset also discards that cycle's push.
    assign fifo_rst     = rst || sb.clear_i;
    assign sb.exp_rdy_o = !full && !rst;
    assign push         = sb.exp_vld_i && sb.exp_rdy_o;
    assign beat         = sb.mon_vld_i && sb.mon_rdy_i;
    assign pop          = beat && !empty;

    stream_scoreboard_fifo #(
        .DEPTH (DEPTH),
        .W     (D)
    ) u_fifo (
        .clk     (clk),
        .rst     (fifo_rst),
        .push_i  (push),
        .data_i  (sb.exp_data_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .cnt_o   (dbg_fifo_cnt_o)
    );

    assign mis_lanes = NUM_LANES'(masked_lane_cmp(MAX_D'(sb.mon_data_i), MAX_D'(head),
                                                  MAX_LANES'(sb.lane_mask_i), LANE_W, NUM_LANES));
    // An underflow beat has nothing to compare against, so every lane is blamed.
    assign err_lanes = empty ? '1 : mis_lanes;
    assign beat_err  = beat && (err_lanes != '0);

    // Next-state: counters, first-error capture, sticky flags, RUN/DONE.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        fbeat_d    = fbeat_q;
        flanes_d   = flanes_q;
        err_d      = err_q;
        under_d    = under_q;
        over_d     = over_q;
        if (beat) begin
            beat_cnt_d = CNT_W'(sat_inc(MAX_W'(beat_cnt_q), CNT_W));
            if (empty) under_d = 1'b1;
            if (beat_err) begin
                err_cnt_d = CNT_W'(sat_inc(MAX_W'(err_cnt_q), CNT_W));
                err_d     = 1'b1;
                if (!err_q) begin
                    fbeat_d  = beat_cnt_q;
                    flanes_d = err_lanes;
                end
            end
            case (state_q)
                RUN:  if (sb.total_i != '0 && beat_cnt_d == sb.total_i) state_d = DONE;
                DONE: over_d = 1'b1;
                default: state_d = RUN;
            endcase
        end
    end

    // State registers; rst and clear_i both return everything to idle RUN.
    always_ff @(posedge clk) begin
        if (rst || sb.clear_i) begin
            state_q    <= RUN;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            fbeat_q    <= '0;
            flanes_q   <= '0;
            err_q      <= 1'b0;
            under_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fbeat_q    <= fbeat_d;
            flanes_q   <= flanes_d;
            err_q      <= err_d;
            under_q    <= under_d;
            over_q     <= over_d;
        end
    end

    assign sb.beat_cnt_o        = beat_cnt_q;
    assign sb.err_cnt_o         = err_cnt_q;
    assign sb.err_o             = err_q;
    assign sb.first_err_beat_o  = fbeat_q;
    assign sb.first_err_lanes_o = flanes_q;
    assign sb.underflow_o       = under_q;
    assign sb.overrun_o         = over_q;
    assign sb.done_o            = (state_q == DONE);
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_stream_scoreboard.sv
// Self-checking bench for stream_scoreboard: a reference model tracks the
// expected FIFO and result registers; per-cycle expected status words go
// into exp_q and are compared after each clock edge.
module tb_stream_scoreboard;
    import stream_scoreboard_pkg::*;

    localparam int LANE_W    = 16;
    localparam int NUM_LANES = 8;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = 16;
    localparam int D         = LANE_W * NUM_LANES;
    localparam int AW        = $clog2(DEPTH);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_scoreboard_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .CNT_W(CNT_W)) bus ();
    state_e      dbg_state;
    logic [AW:0] dbg_cnt;

    stream_scoreboard #(
        .LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sb             (bus),
        .dbg_state_o    (dbg_state),
        .dbg_fifo_cnt_o (dbg_cnt)
    );

    // ---------------- checking ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [D-1:0]  ref_q[$];
    logic [63:0]   exp_q[$];
    logic [15:0]   m_beat, m_err, m_fbeat;
    logic [7:0]    m_flanes;
    bit            m_errf, m_under, m_over, m_done;

    task automatic model_reset();
        ref_q.delete();
        m_beat = '0; m_err = '0; m_fbeat = '0; m_flanes = '0;
        m_errf = 0; m_under = 0; m_over = 0; m_done = 0;
    endtask

    function automatic logic [7:0] lane_diff(input logic [D-1:0] a, input logic [D-1:0] b,
                                             input logic [7:0] m);
        logic [7:0] r;
        r = '0;
        for (int l = 0; l < NUM_LANES; l++)
            if (m[l] && a[l*LANE_W +: LANE_W] !== b[l*LANE_W +: LANE_W]) r[l] = 1'b1;
        return r;
    endfunction

    task automatic model_beat(input logic [D-1:0] md);
        logic [7:0]  lanes;
        logic [15:0] old;
        old = m_beat;
        if (m_beat != 16'hFFFF) m_beat++;
        if (ref_q.size() == 0) begin
            m_under = 1;
            lanes   = 8'hFF;
        end else begin
            lanes = lane_diff(md, ref_q.pop_front(), bus.lane_mask_i);
        end
        if (lanes != 0) begin
            if (m_err != 16'hFFFF) m_err++;
            if (!m_errf) begin
                m_errf   = 1;
                m_fbeat  = old;
                m_flanes = lanes;
            end
        end
        if (m_done) m_over = 1;
        else if (bus.total_i != 0 && m_beat == bus.total_i) m_done = 1;
    endtask

    function automatic logic [63:0] model_pack();
        return {4'b0, m_beat, m_err, m_fbeat, m_flanes, m_done, m_over, m_under, m_errf};
    endfunction

    function automatic logic [63:0] dut_pack();
        return {4'b0, bus.beat_cnt_o, bus.err_cnt_o, bus.first_err_beat_o, bus.first_err_lanes_o,
                bus.done_o, bus.overrun_o, bus.underflow_o, bus.err_o};
    endfunction

    function automatic logic [D-1:0] rand_beat();
        logic [D-1:0] r;
        for (int w = 0; w < D / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: drive, update model from the handshakes seen, then compare.
    task automatic do_cycle(input bit rst_v, input bit clr_v, input bit push_v,
                            input logic [D-1:0] pd, input bit vld_v, input bit rdy_v,
                            input logic [D-1:0] md, output bit pushed);
        rst             = rst_v;
        bus.clear_i     = clr_v;
        bus.exp_vld_i   = push_v;
        bus.exp_data_i  = pd;
        bus.mon_vld_i   = vld_v;
        bus.mon_rdy_i   = rdy_v;
        bus.mon_data_i  = md;
        #1;
        pushed = push_v && bus.exp_rdy_o;
        if (rst_v || clr_v) begin
            model_reset();
            pushed = 0;
        end else begin
            if (vld_v && rdy_v) model_beat(md);
            if (pushed) ref_q.push_back(pd);
        end
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        check("status", dut_pack(), exp_q.pop_front());
    endtask

    task automatic cyc(input bit pv, input logic [D-1:0] pd, input bit bv, input logic [D-1:0] md);
        bit p;
        do_cycle(0, 0, pv, pd, bv, bv, md, p);
    endtask

    // One-cycle rst or clear with a push and a beat offered (both discarded).
    task automatic pulse_rst(input bit use_clear);
        bit p;
        do_cycle(!use_clear, use_clear, 1, rand_beat(), 1, 1, rand_beat(), p);
    endtask

    task automatic run_corrupt(input logic [7:0] mask);
        logic [D-1:0] pd, md;
        pulse_rst(0);
        bus.lane_mask_i = mask;
        bus.total_i     = '0;
        for (int b = 0; b < 12; b++) begin
            pd = rand_beat();
            cyc(1, pd, 0, '0);
            md = pd;
            if (b == 5) md[3*LANE_W + 2] = ~md[3*LANE_W + 2];
            if (b == 9) md[6*LANE_W + 7] = ~md[6*LANE_W + 7];
            cyc(0, '0, 1, md);
        end
    endtask

    task automatic run_abort(input bit use_clear, input string tag);
        bus.total_i     = '0;
        bus.lane_mask_i = 8'hFF;
        pulse_rst(0);
        cyc(0, '0, 1, rand_beat());
        for (int i = 0; i < 3; i++) cyc(1, rand_beat(), 0, '0);
        check({tag, "_pre_cnt"}, 64'(dbg_cnt), 64'd3);
        check({tag, "_pre_err"}, 64'(bus.err_o), 64'd1);
        pulse_rst(use_clear);
        cyc(0, '0, 0, '0);
        check({tag, "_outputs"}, dut_pack(), 64'd0);
        check({tag, "_fifo_empty"}, 64'(dbg_cnt), 64'd0);
        check({tag, "_rdy"}, 64'(bus.exp_rdy_o), 64'd1);
        check({tag, "_state"}, 64'(dbg_state), 64'(RUN));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [D-1:0] pd, md;
        bit           vld, rdy, pv, pushed;
        int           n_push, n_beat, gap, cycles;

        rst = 1'b1;
        bus.clear_i = 0; bus.exp_vld_i = 0; bus.exp_data_i = '0;
        bus.mon_vld_i = 0; bus.mon_rdy_i = 0; bus.mon_data_i = '0;
        bus.lane_mask_i = 8'hFF; bus.total_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy_low", 64'(bus.exp_rdy_o), 64'd0);
        check("reset_outputs", dut_pack(), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(RUN));
        cyc(0, '0, 0, '0);
        check("reset_rdy_high", 64'(bus.exp_rdy_o), 64'd1);

        // 64 matching beats with random gaps.
        bus.total_i = 16'd64;
        n_push = 0; n_beat = 0; cycles = 0;
        gap = $urandom_range(1, 10);
        while (n_beat < 64 && cycles < 3000) begin
            pv = (n_push < 64) && ($urandom_range(0, 3) != 0);
            pd = rand_beat();
            md = rand_beat();
            if (gap > 0) begin
                gap--;
                vld = 1'($urandom_range(0, 1));
                rdy = vld ? 1'b0 : 1'($urandom_range(0, 1));
            end else if (ref_q.size() > 0) begin
                vld = 1; rdy = 1; md = ref_q[0];
                n_beat++;
                gap = $urandom_range(1, 10);
            end else begin
                vld = 0; rdy = 0;
            end
            do_cycle(0, 0, pv, pd, vld, rdy, md, pushed);
            if (pushed) n_push++;
            cycles++;
        end
        check("t1_beats_seen", 64'(n_beat), 64'd64);
        check("t1_beat_cnt", 64'(bus.beat_cnt_o), 64'd64);
        check("t1_done", 64'(bus.done_o), 64'd1);
        check("t1_err_cnt", 64'(bus.err_cnt_o), 64'd0);
        check("t1_overrun", 64'(bus.overrun_o), 64'd0);
        check("t1_state", 64'(dbg_state), 64'(DONE));

        // Corrupted lanes, unmasked then with lane 3 masked off.
        run_corrupt(8'hFF);
        check("t2_err_cnt", 64'(bus.err_cnt_o), 64'd2);
        check("t2_first_beat", 64'(bus.first_err_beat_o), 64'd5);
        check("t2_first_lanes", 64'(bus.first_err_lanes_o), 64'h08);
        run_corrupt(8'hF7);
        check("t2m_err_cnt", 64'(bus.err_cnt_o), 64'd1);
        check("t2m_first_beat", 64'(bus.first_err_beat_o), 64'd9);
        check("t2m_first_lanes", 64'(bus.first_err_lanes_o), 64'h40);

        // Underflow with a same-cycle push: the push is stored, not compared.
        bus.lane_mask_i = 8'hFF;
        pulse_rst(0);
        pd = rand_beat();
        cyc(1, pd, 1, rand_beat());
        check("t3_underflow", 64'(bus.underflow_o), 64'd1);
        check("t3_err_cnt", 64'(bus.err_cnt_o), 64'd1);
        check("t3_first_lanes", 64'(bus.first_err_lanes_o), 64'hFF);
        check("t3_fifo_cnt", 64'(dbg_cnt), 64'd1);
        cyc(0, '0, 1, pd);
        check("t3_match_after", 64'(bus.err_cnt_o), 64'd1);
        check("t3_fifo_drained", 64'(dbg_cnt), 64'd0);

        // Fill the FIFO; ready drops after the last push, returns a cycle after a pop.
        pulse_rst(0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, rand_beat(), 0, '0);
            if (i == DEPTH - 2) check("t4_rdy_before_full", 64'(bus.exp_rdy_o), 64'd1);
        end
        check("t4_rdy_full", 64'(bus.exp_rdy_o), 64'd0);
        check("t4_cnt_full", 64'(dbg_cnt), 64'd16);
        cyc(1, rand_beat(), 0, '0);
        check("t4_cnt_reject", 64'(dbg_cnt), 64'd16);
        cyc(1, rand_beat(), 1, ref_q[0]);
        check("t4_rdy_after_pop", 64'(bus.exp_rdy_o), 64'd1);
        check("t4_cnt_after_pop", 64'(dbg_cnt), 64'd15);
        check("t4_err_cnt", 64'(bus.err_cnt_o), 64'd0);

        // total_i = 4 with 5 beats.
        pulse_rst(0);
        bus.total_i = 16'd4;
        for (int b = 0; b < 5; b++) begin
            pd = rand_beat();
            cyc(1, pd, 0, '0);
            cyc(0, '0, 1, pd);
            if (b == 2) check("t5_not_done_3", 64'(bus.done_o), 64'd0);
            if (b == 3) begin
                check("t5_done_4", 64'(bus.done_o), 64'd1);
                check("t5_no_overrun_4", 64'(bus.overrun_o), 64'd0);
            end
        end
        check("t5_overrun_5", 64'(bus.overrun_o), 64'd1);
        check("t5_beat_cnt", 64'(bus.beat_cnt_o), 64'd5);
        check("t5_done_5", 64'(bus.done_o), 64'd1);

        // Mid-stream rst, then the same with clear_i.
        run_abort(0, "t6_rst");
        run_abort(1, "t6_clear");

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
